// File: rtl/tcm_mem_pipelined.sv
// tcm_mem_pipelined: dual-port tightly coupled memory with configurable latency.
// Has a 64-bit fetch port and a 32-bit tagged data port.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   mem_i_*               fetch port: rd/flush/invalidate/pc in; accept/valid/error/inst out
//   mem_d_*               data port: addr/data_wr/rd/wr strobes/cacheable/req_tag and
//                         invalidate/writeback/flush in;
//                         data_rd/accept/ack/error/resp_tag out
//
// Optional feature: define TCM_MEM_STALL_EN to add LFSR-driven pseudo-random
// backpressure on both accept outputs.
module tcm_mem_pipelined #(
    parameter int          ADDR_W        = 17,
    parameter logic [31:0] BASE_ADDR     = 32'h80000000,
    parameter int          I_LATENCY     = 1,
    parameter int          D_LATENCY     = 1,
    parameter int          D_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_i_rd_i,
    input  logic        mem_i_flush_i,
    input  logic        mem_i_invalidate_i,
    input  logic [31:0] mem_i_pc_i,
    output logic        mem_i_accept_o,
    output logic        mem_i_valid_o,
    output logic        mem_i_error_o,
    output logic [63:0] mem_i_inst_o,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic        mem_d_cacheable_i,
    input  logic [10:0] mem_d_req_tag_i,
    input  logic        mem_d_invalidate_i,
    input  logic        mem_d_writeback_i,
    input  logic        mem_d_flush_i,
    output logic [31:0] mem_d_data_rd_o,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic        mem_d_error_o,
    output logic [10:0] mem_d_resp_tag_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] r_mem [DEPTH];

    // Backpressure source
    logic w_stall;
`ifdef TCM_MEM_STALL_EN
    logic [15:0] r_lfsr;
    always_ff @(posedge clk_i) begin
        if (rst_i) r_lfsr <= 16'hACE1;
        else       r_lfsr <= {r_lfsr[14:0],
                              r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // Fetch port
    logic [31:0] w_i_off;
    logic        w_i_in;
    logic        w_i_take;
    logic [63:0] w_i_rdata;

    assign w_i_off        = mem_i_pc_i - BASE_ADDR;
    assign w_i_in         = (w_i_off[31:ADDR_W] == '0);
    assign mem_i_accept_o = ~rst_i & ~w_stall;
    // flush also cancels a request presented in the same cycle
    assign w_i_take       = mem_i_rd_i & mem_i_accept_o & ~mem_i_flush_i;

    always_comb begin
        w_i_rdata = '0;
        for (int b = 0; b < 8; b++)
            w_i_rdata[8*b +: 8] = r_mem[{w_i_off[ADDR_W-1:3], 3'(b)}];
    end

    logic [I_LATENCY-1:0] r_i_vld;
    logic [I_LATENCY-1:0] r_i_err;
    logic [63:0]          r_i_inst [I_LATENCY];

    always_ff @(posedge clk_i) begin
        if (rst_i || mem_i_flush_i) begin
            r_i_vld <= '0;
            r_i_err <= '0;
            for (int i = 0; i < I_LATENCY; i++) r_i_inst[i] <= '0;
        end else begin
            r_i_vld[0]  <= w_i_take;
            r_i_err[0]  <= w_i_take & ~w_i_in;
            r_i_inst[0] <= (w_i_take & w_i_in) ? w_i_rdata : '0;
            for (int i = 1; i < I_LATENCY; i++) begin
                r_i_vld[i]  <= r_i_vld[i-1];
                r_i_err[i]  <= r_i_err[i-1];
                r_i_inst[i] <= r_i_inst[i-1];
            end
        end
    end

    assign mem_i_valid_o = r_i_vld[I_LATENCY-1];
    assign mem_i_error_o = r_i_err[I_LATENCY-1];
    assign mem_i_inst_o  = r_i_inst[I_LATENCY-1];

    // Data port
    logic [31:0] w_d_off;
    logic        w_d_in;
    logic        w_d_req;
    logic        w_d_take;
    logic        w_d_ack;
    logic [3:0]  w_d_pend;
    logic [31:0] w_d_rdata;
    logic [3:0]  r_d_cnt;

    assign w_d_off = mem_d_addr_i - BASE_ADDR;
    assign w_d_in  = (w_d_off[31:ADDR_W] == '0);
    assign w_d_req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i |
                     mem_d_writeback_i | mem_d_flush_i;
    // a slot retiring this cycle is free for a new request this cycle
    assign w_d_pend = r_d_cnt - {3'b000, w_d_ack};
    assign mem_d_accept_o = ~rst_i & ~w_stall &
                            (w_d_pend < 4'(D_OUTSTANDING));
    assign w_d_take = w_d_req & mem_d_accept_o;

    always_comb begin
        w_d_rdata = '0;
        for (int b = 0; b < 4; b++)
            w_d_rdata[8*b +: 8] = r_mem[{w_d_off[ADDR_W-1:2], 2'(b)}];
    end

    // Read data is the pre-write contents; the write lands at this same edge.
    always_ff @(posedge clk_i) begin
        if (w_d_take && w_d_in) begin
            for (int b = 0; b < 4; b++)
                if (mem_d_wr_i[b])
                    r_mem[{w_d_off[ADDR_W-1:2], 2'(b)}] <= mem_d_data_wr_i[8*b +: 8];
        end
    end

    logic [D_LATENCY-1:0] r_d_vld;
    logic [D_LATENCY-1:0] r_d_err;
    logic [10:0]          r_d_tag  [D_LATENCY];
    logic [31:0]          r_d_data [D_LATENCY];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_d_vld <= '0;
            r_d_err <= '0;
            r_d_cnt <= '0;
            for (int i = 0; i < D_LATENCY; i++) begin
                r_d_tag[i]  <= '0;
                r_d_data[i] <= '0;
            end
        end else begin
            r_d_vld[0]  <= w_d_take;
            r_d_err[0]  <= w_d_take & ~w_d_in;
            r_d_tag[0]  <= w_d_take ? mem_d_req_tag_i : '0;
            r_d_data[0] <= (w_d_take & w_d_in & mem_d_rd_i) ? w_d_rdata : '0;
            for (int i = 1; i < D_LATENCY; i++) begin
                r_d_vld[i]  <= r_d_vld[i-1];
                r_d_err[i]  <= r_d_err[i-1];
                r_d_tag[i]  <= r_d_tag[i-1];
                r_d_data[i] <= r_d_data[i-1];
            end
            if (w_d_take && !w_d_ack)      r_d_cnt <= r_d_cnt + 4'd1;
            else if (!w_d_take && w_d_ack) r_d_cnt <= r_d_cnt - 4'd1;
        end
    end

    assign w_d_ack          = r_d_vld[D_LATENCY-1];
    assign mem_d_ack_o      = w_d_ack;
    assign mem_d_error_o    = r_d_err[D_LATENCY-1];
    assign mem_d_resp_tag_o = r_d_tag[D_LATENCY-1];
    assign mem_d_data_rd_o  = r_d_data[D_LATENCY-1];

    logic w_unused;
    assign w_unused = &{1'b0, mem_i_invalidate_i, mem_d_cacheable_i,
                        w_i_off[2:0], w_d_off[1:0]};

    // Backdoor access by window offset for preloading in simulation
    task automatic write(input logic [ADDR_W-1:0] addr, input logic [7:0] data);
        r_mem[addr] <= data;
    endtask

    function automatic logic [7:0] read(input logic [ADDR_W-1:0] addr);
        return r_mem[addr];
    endfunction

endmodule

// File: tb/tb_tcm_mem_pipelined.sv
// tb_tcm_mem_pipelined: scoreboard bench for tcm_mem_pipelined.
// Instance A uses default latencies; instance B uses I_LATENCY=3, D_LATENCY=4.
module tb_tcm_mem_pipelined;

    localparam int AIL = 1, ADL = 1, BIL = 3, BDL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] data;
        logic        err;
        logic [10:0] tag;
        int          due;
    } exp_t;

    exp_t qai[$], qad[$], qbi[$], qbd[$];
    exp_t ea_i, ea_d, eb_i, eb_d;

    // Instance A signals
    logic        a_rst, a_i_rd, a_i_flush, a_i_inv;
    logic [31:0] a_i_pc;
    logic        a_i_acc, a_i_vld, a_i_err;
    logic [63:0] a_i_inst;
    logic [31:0] a_d_addr, a_d_wd, a_d_rdata;
    logic        a_d_rd, a_d_inv, a_d_wb, a_d_fl;
    logic [3:0]  a_d_wr;
    logic [10:0] a_d_tag, a_d_rtag;
    logic        a_d_acc, a_d_ack, a_d_err;

    // Instance B signals
    logic        b_rst, b_i_rd, b_i_flush, b_i_inv;
    logic [31:0] b_i_pc;
    logic        b_i_acc, b_i_vld, b_i_err;
    logic [63:0] b_i_inst;
    logic [31:0] b_d_addr, b_d_wd, b_d_rdata;
    logic        b_d_rd, b_d_inv, b_d_wb, b_d_fl;
    logic [3:0]  b_d_wr;
    logic [10:0] b_d_tag, b_d_rtag;
    logic        b_d_acc, b_d_ack, b_d_err;

    tcm_mem_pipelined u_a (
        .clk_i(clk), .rst_i(a_rst),
        .mem_i_rd_i(a_i_rd), .mem_i_flush_i(a_i_flush),
        .mem_i_invalidate_i(a_i_inv), .mem_i_pc_i(a_i_pc),
        .mem_i_accept_o(a_i_acc), .mem_i_valid_o(a_i_vld),
        .mem_i_error_o(a_i_err), .mem_i_inst_o(a_i_inst),
        .mem_d_addr_i(a_d_addr), .mem_d_data_wr_i(a_d_wd),
        .mem_d_rd_i(a_d_rd), .mem_d_wr_i(a_d_wr),
        .mem_d_cacheable_i(1'b1), .mem_d_req_tag_i(a_d_tag),
        .mem_d_invalidate_i(a_d_inv), .mem_d_writeback_i(a_d_wb),
        .mem_d_flush_i(a_d_fl), .mem_d_data_rd_o(a_d_rdata),
        .mem_d_accept_o(a_d_acc), .mem_d_ack_o(a_d_ack),
        .mem_d_error_o(a_d_err), .mem_d_resp_tag_o(a_d_rtag)
    );

    tcm_mem_pipelined #(.I_LATENCY(BIL), .D_LATENCY(BDL), .D_OUTSTANDING(2)) u_b (
        .clk_i(clk), .rst_i(b_rst),
        .mem_i_rd_i(b_i_rd), .mem_i_flush_i(b_i_flush),
        .mem_i_invalidate_i(b_i_inv), .mem_i_pc_i(b_i_pc),
        .mem_i_accept_o(b_i_acc), .mem_i_valid_o(b_i_vld),
        .mem_i_error_o(b_i_err), .mem_i_inst_o(b_i_inst),
        .mem_d_addr_i(b_d_addr), .mem_d_data_wr_i(b_d_wd),
        .mem_d_rd_i(b_d_rd), .mem_d_wr_i(b_d_wr),
        .mem_d_cacheable_i(1'b0), .mem_d_req_tag_i(b_d_tag),
        .mem_d_invalidate_i(b_d_inv), .mem_d_writeback_i(b_d_wb),
        .mem_d_flush_i(b_d_fl), .mem_d_data_rd_o(b_d_rdata),
        .mem_d_accept_o(b_d_acc), .mem_d_ack_o(b_d_ack),
        .mem_d_error_o(b_d_err), .mem_d_resp_tag_o(b_d_rtag)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: response with no pending request", nm);
    endtask

    // Monitors: pop and compare whenever a response is presented
    always @(negedge clk) begin
        if (a_i_vld === 1'b1) begin
            if (qai.size() == 0) unexpected("a_fetch");
            else begin
                ea_i = qai.pop_front();
                chk("a_fetch_inst", a_i_inst, ea_i.data);
                chk("a_fetch_err", 64'(a_i_err), 64'(ea_i.err));
                chk("a_fetch_lat", 64'(cyc), 64'(ea_i.due));
            end
        end
        if (a_d_ack === 1'b1) begin
            if (qad.size() == 0) unexpected("a_data");
            else begin
                ea_d = qad.pop_front();
                chk("a_data_rd", 64'(a_d_rdata), ea_d.data);
                chk("a_data_err", 64'(a_d_err), 64'(ea_d.err));
                chk("a_data_tag", 64'(a_d_rtag), 64'(ea_d.tag));
                chk("a_data_lat", 64'(cyc), 64'(ea_d.due));
            end
        end
        if (b_i_vld === 1'b1) begin
            if (qbi.size() == 0) unexpected("b_fetch");
            else begin
                eb_i = qbi.pop_front();
                chk("b_fetch_inst", b_i_inst, eb_i.data);
                chk("b_fetch_err", 64'(b_i_err), 64'(eb_i.err));
                chk("b_fetch_lat", 64'(cyc), 64'(eb_i.due));
            end
        end
        if (b_d_ack === 1'b1) begin
            if (qbd.size() == 0) unexpected("b_data");
            else begin
                eb_d = qbd.pop_front();
                chk("b_data_rd", 64'(b_d_rdata), eb_d.data);
                chk("b_data_err", 64'(b_d_err), 64'(eb_d.err));
                chk("b_data_tag", 64'(b_d_rtag), 64'(eb_d.tag));
                chk("b_data_lat", 64'(cyc), 64'(eb_d.due));
            end
        end
    end

    task automatic a_dreq(input logic [31:0] addr, input logic [31:0] wd,
                          input logic rd, input logic [3:0] wr, input logic [2:0] mnt,
                          input logic [10:0] tag, input logic [31:0] ed, input logic ee);
        bit ok = 0;
        a_d_addr = addr; a_d_wd = wd; a_d_rd = rd; a_d_wr = wr; a_d_tag = tag;
        {a_d_fl, a_d_wb, a_d_inv} = mnt;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = (a_d_acc === 1'b1);
        end
        if (!ok) unexpected("a_dreq_timeout");
        else qad.push_back('{data: {32'h0, ed}, err: ee, tag: tag, due: cyc + ADL});
        @(posedge clk); #1;
        a_d_rd = 0; a_d_wr = 0; {a_d_fl, a_d_wb, a_d_inv} = 3'b000;
    endtask

    task automatic b_dreq(input logic [31:0] addr, input logic [31:0] wd,
                          input logic rd, input logic [3:0] wr,
                          input logic [10:0] tag, input logic [31:0] ed);
        bit ok = 0;
        b_d_addr = addr; b_d_wd = wd; b_d_rd = rd; b_d_wr = wr; b_d_tag = tag;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = (b_d_acc === 1'b1);
        end
        if (!ok) unexpected("b_dreq_timeout");
        else qbd.push_back('{data: {32'h0, ed}, err: 1'b0, tag: tag, due: cyc + BDL});
        @(posedge clk); #1;
        b_d_rd = 0; b_d_wr = 0;
    endtask

    task automatic a_fetch(input logic [31:0] pc, input logic [63:0] ei, input logic ee);
        bit ok = 0;
        a_i_pc = pc; a_i_rd = 1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = (a_i_acc === 1'b1);
        end
        if (!ok) unexpected("a_fetch_timeout");
        else qai.push_back('{data: ei, err: ee, tag: '0, due: cyc + AIL});
        @(posedge clk); #1;
        a_i_rd = 0;
    endtask

    task automatic b_fetch(input logic [31:0] pc, input logic [63:0] ei);
        bit ok = 0;
        b_i_pc = pc; b_i_rd = 1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = (b_i_acc === 1'b1);
        end
        if (!ok) unexpected("b_fetch_timeout");
        else qbi.push_back('{data: ei, err: 1'b0, tag: '0, due: cyc + BIL});
        @(posedge clk); #1;
        b_i_rd = 0;
    endtask

    logic [4:0] acc_pat;

    initial begin
        a_rst = 1; a_i_rd = 0; a_i_flush = 0; a_i_inv = 0; a_i_pc = '0;
        a_d_addr = '0; a_d_wd = '0; a_d_rd = 0; a_d_wr = '0; a_d_tag = '0;
        a_d_inv = 0; a_d_wb = 0; a_d_fl = 0;
        b_rst = 1; b_i_rd = 0; b_i_flush = 0; b_i_inv = 0; b_i_pc = '0;
        b_d_addr = '0; b_d_wd = '0; b_d_rd = 0; b_d_wr = '0; b_d_tag = '0;
        b_d_inv = 0; b_d_wb = 0; b_d_fl = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_i_acc", 64'(a_i_acc), 64'h0);
        chk("rst_a_d_acc", 64'(a_d_acc), 64'h0);
        chk("rst_a_i_vld", 64'(a_i_vld), 64'h0);
        chk("rst_a_d_ack", 64'(a_d_ack), 64'h0);
        chk("rst_a_inst", a_i_inst, 64'h0);
        chk("rst_b_d_acc", 64'(b_d_acc), 64'h0);
        @(posedge clk); #1;
        a_rst = 0; b_rst = 0;
        @(negedge clk);
        chk("post_rst_a_i_acc", 64'(a_i_acc), 64'h1);
        chk("post_rst_a_d_acc", 64'(a_d_acc), 64'h1);
        @(posedge clk); #1;

        // Preload and fetch (low word at lower address)
        a_dreq(32'h80000000, 32'h04030201, 0, 4'hF, 3'b000, 11'd1, 32'h0, 0);
        a_dreq(32'h80000004, 32'h08070605, 0, 4'hF, 3'b000, 11'd2, 32'h0, 0);
        a_fetch(32'h80000000, 64'h0807060504030201, 0);

        // Write then read back-to-back
        a_dreq(32'h80000100, 32'hDEADBEEF, 0, 4'hF, 3'b000, 11'd5, 32'h0, 0);
        a_dreq(32'h80000100, 32'h0, 1, 4'h0, 3'b000, 11'd6, 32'hDEADBEEF, 0);
        a_dreq(32'h80000104, 32'hCAFEF00D, 0, 4'hF, 3'b000, 11'd7, 32'h0, 0);
        a_fetch(32'h80000104, 64'hCAFEF00D_DEADBEEF, 0);

        // Byte strobes, read-with-write returns old data
        a_dreq(32'h80000200, 32'h11223344, 0, 4'hF, 3'b000, 11'd8, 32'h0, 0);
        a_dreq(32'h80000202, 32'h0000AA00, 0, 4'b0010, 3'b000, 11'd9, 32'h0, 0);
        a_dreq(32'h80000200, 32'h0, 1, 4'h0, 3'b000, 11'd10, 32'h1122AA44, 0);
        a_dreq(32'h80000200, 32'h55667788, 1, 4'hF, 3'b000, 11'd11, 32'h1122AA44, 0);
        a_dreq(32'h80000200, 32'h0, 1, 4'h0, 3'b000, 11'd12, 32'h55667788, 0);
        a_dreq(32'h80000200, 32'h0, 0, 4'h0, 3'b001, 11'd13, 32'h0, 0);
        a_dreq(32'h80000200, 32'h0, 0, 4'h0, 3'b100, 11'd1023, 32'h0, 0);

        // Window edges
        a_dreq(32'h00001000, 32'h0, 1, 4'h0, 3'b000, 11'd14, 32'h0, 1);
        a_fetch(32'h90000000, 64'h0, 1);
        a_dreq(32'h8001FFFC, 32'hA5A55A5A, 0, 4'hF, 3'b000, 11'd15, 32'h0, 0);
        a_dreq(32'h8001FFFC, 32'h0, 1, 4'h0, 3'b000, 11'd16, 32'hA5A55A5A, 0);
        a_dreq(32'h80020000, 32'hFFFFFFFF, 0, 4'hF, 3'b000, 11'd17, 32'h0, 1);
        a_dreq(32'h80020000, 32'h0, 1, 4'h0, 3'b000, 11'd18, 32'h0, 1);
        a_dreq(32'h80000000, 32'h0, 1, 4'h0, 3'b000, 11'd19, 32'h04030201, 0);

        // Instance B: outstanding limit
        b_dreq(32'h80000040, 32'h13579BDF, 0, 4'hF, 11'd1, 32'h0);
        b_dreq(32'h80000044, 32'h2468ACE0, 0, 4'hF, 11'd2, 32'h0);
        repeat (10) @(posedge clk); #1;
        acc_pat = 5'b10011;
        b_d_addr = 32'h80000040; b_d_rd = 1;
        for (int k = 0; k < 5; k++) begin
            b_d_tag = 11'(20 + k);
            @(negedge clk);
            chk($sformatf("b_accept_%0d", k), 64'(b_d_acc), 64'(acc_pat[k]));
            if (b_d_acc === 1'b1)
                qbd.push_back('{data: 64'h13579BDF, err: 1'b0, tag: 11'(20 + k), due: cyc + BDL});
            @(posedge clk); #1;
        end
        b_d_rd = 0;
        repeat (10) @(posedge clk); #1;

        // Fetch flush: in flight, and same-cycle request
        b_i_pc = 32'h80000040; b_i_rd = 1;
        @(posedge clk); #1;
        b_i_rd = 0; b_i_flush = 1;
        @(posedge clk); #1;
        b_i_flush = 0; b_i_rd = 1;
        @(posedge clk); #1;
        b_i_rd = 1; b_i_flush = 1;
        @(posedge clk); #1;
        b_i_rd = 0; b_i_flush = 0;
        repeat (6) @(posedge clk); #1;
        b_fetch(32'h80000040, 64'h2468ACE0_13579BDF);
        repeat (6) @(posedge clk); #1;

        // Reset with a read in flight
        b_dreq(32'h80000040, 32'h0, 1, 4'h0, 11'd30, 32'h13579BDF);
        @(posedge clk); #1;
        qbd.delete();
        b_rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_b_ack", 64'(b_d_ack), 64'h0);
        chk("midrst_b_acc", 64'(b_d_acc), 64'h0);
        chk("midrst_b_rdata", 64'(b_d_rdata), 64'h0);
        chk("midrst_b_tag", 64'(b_d_rtag), 64'h0);
        @(posedge clk); #1;
        b_rst = 0;
        repeat (10) @(posedge clk);

        chk("pending_a_fetch", 64'(qai.size()), 64'h0);
        chk("pending_a_data", 64'(qad.size()), 64'h0);
        chk("pending_b_fetch", 64'(qbi.size()), 64'h0);
        chk("pending_b_data", 64'(qbd.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
